// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data paths.
// Data has priority; a starvation counter forces an IF grant after STARVE_LIMIT back-to-back D wins.
module sram_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int WAIT_CYCLES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout,
  output logic          busy
);

  // state  | meaning
  // IDLE   | no access; arbitrate and latch the winner's request
  // ACCESS | sram_cs held for WAIT_CYCLES cycles
  // RESP   | one-cycle done pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          owner_q, owner_d;   // 1 = D path owns the access
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_d;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          grant_d    = d_req && !(if_req && (starve_cnt_q == STARVE_MAX));
          owner_d    = grant_d;
          wait_cnt_d = WAIT_LOAD;
          state_d    = ACCESS;
          if (grant_d) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            if (if_req && (starve_cnt_q < STARVE_MAX))
              starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            we_d         = 1'b0;
            addr_d       = if_addr;
            wdata_d      = '0;
            starve_cnt_d = '0;
          end
        end
      end
      ACCESS: begin
        if (wait_cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q) d_rdata_d  = sram_dout;
            else         if_rdata_d = sram_dout;
          end
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Pins decode only registered state, so request inputs can never glitch them.
  assign sram_cs   = (state_q == ACCESS);
  assign sram_oe   = sram_cs && !we_q;
  assign sram_we   = sram_cs && we_q;
  assign sram_addr = sram_cs ? addr_q : '0;
  assign sram_din  = sram_we ? wdata_q : '0;
  assign if_done   = (state_q == RESP) && !owner_q;
  assign d_done    = (state_q == RESP) && owner_q;
  assign busy      = (state_q != IDLE);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
